// File: rtl/serpent_round_engine.sv
// Iterative Serpent round controller: key mixing into an external 4-bit-lane s_box stage,
// linear transform on its result, 32 rounds at one per clock, then final key whitening.
module serpent_round_engine #(
    parameter int NROUNDS = 32
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic [5:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [2:0]   sbox_sel,
    output logic [127:0] sbox_in,
    input  logic [127:0] sbox_out,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'(NROUNDS - 1);
    localparam logic [5:0] FINAL_KEY  = 6'(NROUNDS);

    state_t         r_state;
    logic [127:0]   r_state_reg;
    logic [4:0]     r_round;
    logic           r_busy;
    logic           r_done;
    logic [127:0]   r_ciphertext;
    logic [127:0]   w_lt;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] linearTransform(input logic [127:0] x);
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        w0 = x[31:0];
        w1 = x[63:32];
        w2 = x[95:64];
        w3 = x[127:96];
        w0 = rotl32(w0, 13);
        w2 = rotl32(w2, 3);
        w1 = w1 ^ w0 ^ w2;
        w3 = w3 ^ w2 ^ (w0 << 3);
        w1 = rotl32(w1, 1);
        w3 = rotl32(w3, 7);
        w0 = w0 ^ w1 ^ w3;
        w2 = w2 ^ w3 ^ (w1 << 7);
        w0 = rotl32(w0, 5);
        w2 = rotl32(w2, 22);
        return {w3, w2, w1, w0};
    endfunction

    assign w_lt       = linearTransform(sbox_out);
    assign rk_idx     = (r_state == S_FINAL) ? FINAL_KEY : {1'b0, r_round};
    assign sbox_sel   = r_round[2:0];
    assign sbox_in    = r_state_reg ^ rk;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ciphertext = r_ciphertext;

    // The last round skips the linear transform; whitening with K32 happens in FINAL.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_state_reg  <= '0;
            r_round      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ciphertext <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state_reg <= plaintext;
                        r_round     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_round == LAST_ROUND) begin
                        r_state_reg <= sbox_out;
                        r_state     <= S_FINAL;
                    end else begin
                        r_state_reg <= w_lt;
                        r_round     <= r_round + 5'd1;
                    end
                end
                S_FINAL: begin
                    r_ciphertext <= r_state_reg ^ rk;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_round      <= '0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serpent_round_engine.sv
// Scoreboard bench for serpent_round_engine: a behavioural Serpent model (no IP/FP) predicts
// each ciphertext when a block is issued; a monitor pops and compares on every done pulse.
module tb_serpent_round_engine;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [127:0] plaintext;
    logic [5:0]   rk_idx;
    logic [127:0] rk;
    logic [2:0]   sbox_sel;
    logic [127:0] sbox_in;
    logic [127:0] sbox_out;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    int           testsRun;
    int           testsFailed;
    logic [127:0] expQ [$];
    logic [127:0] keys [0:32];
    bit           sboxMode;

    int sboxTab [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    serpent_round_engine #(.NROUNDS(32)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .plaintext  (plaintext),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .sbox_sel   (sbox_sel),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibble-wise s_box layer; mode 1 turns selector 0 into the identity stub.
    function automatic logic [127:0] sboxLayer(input logic [127:0] x, input logic [2:0] sel, input bit mode);
        logic [127:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            if (mode && sel == 3'd0) y[4*j +: 4] = x[4*j +: 4];
            else                     y[4*j +: 4] = 4'(sboxTab[sel][x[4*j +: 4]]);
        end
        return y;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] ltModel(input logic [127:0] x);
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = x[32*i +: 32];
        w[0] = rotl(w[0], 13);
        w[2] = rotl(w[2], 3);
        w[1] = w[1] ^ w[0] ^ w[2];
        w[3] = w[3] ^ w[2] ^ (w[0] << 3);
        w[1] = rotl(w[1], 1);
        w[3] = rotl(w[3], 7);
        w[0] = w[0] ^ w[1] ^ w[3];
        w[2] = w[2] ^ w[3] ^ (w[1] << 7);
        w[0] = rotl(w[0], 5);
        w[2] = rotl(w[2], 22);
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [127:0] serpentModel(input logic [127:0] pt);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r < 32; r++) begin
            s = sboxLayer(s ^ keys[r], 3'(r % 8), 1'b0);
            if (r < 31) s = ltModel(s);
        end
        return s ^ keys[32];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign rk       = (rk_idx <= 6'd32) ? keys[rk_idx] : '0;
    assign sbox_out = sboxLayer(sbox_in, sbox_sel, sboxMode);

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic randomizeKeys();
        for (int i = 0; i <= 32; i++) keys[i] = rand128();
    endtask

    task automatic zeroKeys();
        for (int i = 0; i <= 32; i++) keys[i] = '0;
    endtask

    // Called at a negedge: presents a block, queueing its ciphertext if it should complete.
    task automatic applyStimulus(input logic [127:0] pt, input bit expectDone);
        plaintext = pt;
        start     = 1'b1;
        if (expectDone) expQ.push_back(serpentModel(pt));
    endtask

    task automatic waitDone(input bit holdStart);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !holdStart) start = 1'b0;
        end while (!done && n < 60);
        checkOutput("latency", 128'(n), 128'd34);
    endtask

    // Monitor: every done pulse consumes one expected ciphertext and must be one cycle wide.
    initial begin
        logic prevDone;
        logic [127:0] exp;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                checkOutput("doneWidth", 128'(prevDone), 128'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 128'(expQ.size()), 128'd1);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("ciphertext", ciphertext, exp);
                end
            end
            prevDone = done;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  c;
        bit  sawDone;
        logic [127:0] ptC;

        testsRun    = 0;
        testsFailed = 0;
        sboxMode    = 1'b0;
        n_rst       = 1'b0;
        start       = 1'b0;
        plaintext   = '0;
        zeroKeys();

        // Reset and idle hold
        repeat (2) @(negedge clk);
        checkOutput("resetBusyDone", {busy, done}, 2'b00);
        checkOutput("resetCipher", ciphertext, '0);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idleCtrl", {busy, done, rk_idx, sbox_sel}, '0);
            checkOutput("idleCipher", ciphertext, '0);
        end

        // Zero plaintext, zero keys: index stepping and exact done timing
        applyStimulus('0, 1'b1);
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            checkOutput("busyDoneRun", {busy, done}, 2'b10);
            if (i < 32) begin
                checkOutput("rkIdx", rk_idx, 128'(i));
                checkOutput("sboxSel", sbox_sel, 128'(i % 8));
            end else begin
                checkOutput("rkIdxFinal", rk_idx, 128'd32);
            end
        end
        @(negedge clk);
        checkOutput("busyDoneEnd", {busy, done}, 2'b01);
        repeat (3) @(negedge clk);

        // Single round datapath with identity s_box on selector 0
        sboxMode = 1'b1;
        plaintext = 128'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("round0SboxIn", sbox_in, 128'h1);
        @(negedge clk);
        checkOutput("ltSanity", sbox_in,
                    {32'h0080_0000, 32'h0000_2800, 32'h0000_4000, 32'h100C_0000});
        n_rst = 1'b0;
        #1;
        checkOutput("abortCipher", ciphertext, '0);
        @(negedge clk);
        n_rst = 1'b1;
        sboxMode = 1'b0;
        repeat (2) @(negedge clk);

        // Starts while busy are ignored; start held through done chains a second block
        randomizeKeys();
        ptC = rand128();
        applyStimulus(rand128(), 1'b1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            case (c)
                1, 7, 22: start = 1'b0;
                6, 21: begin
                    start = 1'b1;
                    plaintext = rand128();
                end
                26: begin
                    start = 1'b1;
                    plaintext = ptC;
                end
                default: ;
            endcase
        end while (!done && c < 60);
        checkOutput("latencyIgnored", 128'(c), 128'd34);
        randomizeKeys();
        expQ.push_back(serpentModel(ptC));
        waitDone(1'b0);
        repeat (3) @(negedge clk);

        // Asynchronous abort at round 17
        randomizeKeys();
        applyStimulus(rand128(), 1'b0);
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        checkOutput("rkIdxRound17", rk_idx, 128'd17);
        n_rst = 1'b0;
        #1;
        checkOutput("abortBusyDone", {busy, done}, 2'b00);
        checkOutput("abortCipher17", ciphertext, '0);
        @(negedge clk);
        n_rst = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterAbort", 128'(sawDone), 128'd0);
        randomizeKeys();
        applyStimulus(rand128(), 1'b1);
        waitDone(1'b0);
        repeat (2) @(negedge clk);

        // 100 random blocks back-to-back
        randomizeKeys();
        applyStimulus(rand128(), 1'b1);
        for (int k = 0; k < 100; k++) begin
            waitDone(k < 99);
            if (k < 99) begin
                randomizeKeys();
                applyStimulus(rand128(), 1'b1);
            end
        end
        repeat (4) @(negedge clk);
        checkOutput("queueDrained", 128'(expQ.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/serpent_round_engine.md
Name: serpent_round_engine

Overview:
- Iterative Serpent encryption round controller sitting on both sides of the existing 4-bit-lane s_box stage.
- Upstream of s_box: performs round-key mixing and drives s_box select and data.
- Downstream of s_box: consumes its output and applies the Serpent linear transform (LT).
- Sequences 32 rounds plus final key whitening, one round per clock. Round keys come from the key-schedule memory; IP/FP permutation is handled outside this block.

Parameters:
- NROUNDS, 32, number of S-box rounds. Fixed by the algorithm; other values unsupported.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin encryption of plaintext. Sampled only in IDLE.
- plaintext  input  128  block to encrypt. Captured on the accepted start edge.
- rk_idx  output  6  round-key index presented to key-schedule memory (0..32)
- rk  input  128  round key K[rk_idx]. Combinational from memory, valid in the same cycle.
- sbox_sel  output  3  s_box select = round[2:0]
- sbox_in  output  128  = state_reg ^ rk, continuously
- sbox_out  input  128  s_box result for sbox_in/sbox_sel, same cycle (combinational)
- busy  output  1  high while a block is in flight
- done  output  1  one-cycle pulse when ciphertext is valid
- ciphertext  output  128  result. Held stable until the next done.

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, state_reg=0, round=0, ciphertext=0, busy=0, done=0. Consequently rk_idx=0, sbox_sel=0, sbox_in=rk.
- Reset mid-operation aborts the block. No done is produced and ciphertext returns to 0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - done=0 except the cycle immediately after FINAL.
  - start=1 at edge E0: state_reg<=plaintext, round<=0, busy<=1, go to ROUND.
- ROUND (rounds 0..31, one cycle each):
  - rk_idx=round, sbox_sel=round[2:0].
  - round<31: state_reg<=LT(sbox_out), round<=round+1.
  - round==31: state_reg<=sbox_out (no LT), go to FINAL.
- FINAL (one cycle):
  - rk_idx=32.
  - At the edge: ciphertext<=state_reg^rk, done<=1, busy<=0, go to IDLE.
- Latency: start accepted at E0 → 32 ROUND cycles → FINAL → done high during the cycle after edge E33. Throughput is 1 block per 34 cycles.
- done deasserts after exactly one cycle.
- start while busy=1 is ignored: no restart, no capture.
- start in the same cycle that done is high is accepted (back-to-back blocks). Next done comes 34 cycles later.
- round counter is 5 bits and never wraps inside a block. rk_idx = {0,round} in ROUND and 6'd32 in FINAL.
- LT on words W0=[31:0], W1=[63:32], W2=[95:64], W3=[127:96], in order:
  1. W0<<<=13
  2. W2<<<=3
  3. W1^=W0^W2
  4. W3^=W2^(W0<<3)
  5. W1<<<=1
  6. W3<<<=7
  7. W0^=W1^W3
  8. W2^=W3^(W1<<7)
  9. W0<<<=5
  10. W2<<<=22
- Notation: `<<<` is a 32-bit rotate. `<<` is a 32-bit logical shift with truncation.
- LT is pure combinational within the ROUND cycle. No extra pipeline registers.
- LT sanity vector: W0=1, W1=W2=W3=0 gives W0=0x100C0000, W1=0x00004000, W2=0x00002800, W3=0x00800000.
- LT(0)=0.

Test Plan:
- Reset, then idle: busy=0, done=0, ciphertext=0, rk_idx=0, sbox_sel=0 → all hold for 10 cycles with start=0.
- Single block with golden model (software Serpent without IP/FP, same LT word order, same s_box tables), plaintext=0, all 33 round keys=0:
  - rk_idx steps 0,1,…,31,32 on consecutive cycles.
  - sbox_sel steps 0..7 repeating.
  - done pulses once, exactly 34 cycles after the start edge.
  - ciphertext equals the model output.
- Single-round datapath check: plaintext=0x1 with K0=0, so sbox_in=0x1 in the first ROUND cycle. Stub s_box returns identity for sel 0 only → the state_reg after the first edge equals the LT sanity vector above.
- start asserted again at cycles 5 and 20 of an ongoing block with a different plaintext → ignored; ciphertext matches the first plaintext only. Then start held high through done → second block accepted on the done cycle and completes 34 cycles later with the correct result.
- n_rst pulsed low at round 17 → busy=0, ciphertext=0 immediately (asynchronous), no done pulse. A fresh start afterwards completes correctly.
- 100 random plaintext/key-set pairs back-to-back → every ciphertext matches the golden model, and every done is exactly one cycle wide.
